// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART-driven instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHK    = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         WORD_BYTES    = 4;
  localparam logic [7:0] CHK_INIT      = 8'h00;

  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
    return chk ^ data;
  endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// UART byte input plus imem write port and load status, bundled for the loader.
interface imem_uart_loader_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_en;
  logic [3:0]  imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;
  logic        memcon_prog_ena;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_written;

  modport master (
    input  rx_valid, rx_data,
    output imem_en, imem_we, imem_addr, imem_din,
    output memcon_prog_ena, load_done, load_err, words_written
  );

  modport slave (
    output rx_valid, rx_data,
    input  imem_en, imem_we, imem_addr, imem_din,
    input  memcon_prog_ena, load_done, load_err, words_written
  );

endinterface

// File: rtl/imem_uart_loader_byte_asm.sv
// Steers incoming bytes into little-endian word lanes and flags the 4th byte.
module loader_byte_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [31:0] word_r;
  logic [1:0]  byte_idx_r;
  logic [31:0] word_s;

  // The merged word includes the byte being accepted this cycle, so a write can launch on the same edge.
  always_comb begin
    word_s = word_r;
    case (byte_idx_r)
      2'd0:    word_s[7:0]   = byte_in;
      2'd1:    word_s[15:8]  = byte_in;
      2'd2:    word_s[23:16] = byte_in;
      default: word_s[31:24] = byte_in;
    endcase
  end

  assign word       = word_s;
  assign word_ready = accept && (byte_idx_r == 2'(WORD_BYTES - 1));

  // Lane register and byte index; index wraps 3->0 naturally.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      word_r     <= 32'h0000_0000;
      byte_idx_r <= 2'd0;
    end else if (clear) begin
      word_r     <= 32'h0000_0000;
      byte_idx_r <= 2'd0;
    end else if (accept) begin
      word_r     <= word_s;
      byte_idx_r <= byte_idx_r + 2'd1;
    end else begin
      word_r     <= word_r;
      byte_idx_r <= byte_idx_r;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Parses a framed UART download (sync, count, LE words, XOR checksum) and writes
// it into imem, holding memcon_prog_ena for the whole load.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH_WORDS = 1024,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input logic                clk,
  input logic                Rst_n,
  imem_uart_loader_if.master bus
);

  loader_state_t state_r, next_state_s;

  logic [15:0] cnt_n_r;
  logic [15:0] word_idx_r;
  logic [15:0] words_written_r;
  logic [7:0]  chk_r;
  logic [31:0] to_cnt_r;

  logic        imem_en_r;
  logic [3:0]  imem_we_r;
  logic [31:0] imem_addr_r;
  logic [31:0] imem_din_r;
  logic        prog_ena_r;
  logic        load_done_r;
  logic        load_err_r;

  logic        timing_s;
  logic        timeout_s;
  logic        last_word_s;
  logic        accept_s;
  logic        clear_s;
  logic [15:0] n_full_s;
  logic [31:0] word_s;
  logic        word_ready_s;

  logic        imem_en_s;
  logic        prog_ena_s;
  logic        load_done_s;
  logic        load_err_s;

  assign timing_s    = (state_r == ST_CNT_LO) || (state_r == ST_CNT_HI) ||
                       (state_r == ST_DATA)   || (state_r == ST_CHK);
  assign timeout_s   = timing_s && !bus.rx_valid && (to_cnt_r == 32'(TIMEOUT_CYC - 1));
  assign last_word_s = ((word_idx_r + 16'd1) == cnt_n_r);
  // A byte landing in WRITE belongs to the next word unless that word was the last one.
  assign accept_s    = bus.rx_valid &&
                       ((state_r == ST_DATA) || ((state_r == ST_WRITE) && !last_word_s));
  assign clear_s     = (state_r == ST_CNT_LO) || (state_r == ST_CNT_HI);
  assign n_full_s    = {bus.rx_data, cnt_n_r[7:0]};

  loader_byte_asm u_byte_asm (
    .clk        (clk),
    .Rst_n      (Rst_n),
    .clear      (clear_s),
    .accept     (accept_s),
    .byte_in    (bus.rx_data),
    .word       (word_s),
    .word_ready (word_ready_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) next_state_s = ST_CNT_LO;
        else                                            next_state_s = ST_IDLE;
      end
      ST_CNT_LO: begin
        if (timeout_s)         next_state_s = ST_ERR;
        else if (bus.rx_valid) next_state_s = ST_CNT_HI;
        else                   next_state_s = ST_CNT_LO;
      end
      ST_CNT_HI: begin
        if (timeout_s) begin
          next_state_s = ST_ERR;
        end else if (bus.rx_valid) begin
          if ({16'd0, n_full_s} > 32'(DEPTH_WORDS)) next_state_s = ST_ERR;
          else if (n_full_s == 16'd0)               next_state_s = ST_CHK;
          else                                      next_state_s = ST_DATA;
        end else begin
          next_state_s = ST_CNT_HI;
        end
      end
      ST_DATA: begin
        if (timeout_s)         next_state_s = ST_ERR;
        else if (word_ready_s) next_state_s = ST_WRITE;
        else                   next_state_s = ST_DATA;
      end
      ST_WRITE: begin
        if (last_word_s) begin
          if (bus.rx_valid) next_state_s = (bus.rx_data == chk_r) ? ST_DONE : ST_ERR;
          else              next_state_s = ST_CHK;
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_CHK: begin
        if (timeout_s)         next_state_s = ST_ERR;
        else if (bus.rx_valid) next_state_s = (bus.rx_data == chk_r) ? ST_DONE : ST_ERR;
        else                   next_state_s = ST_CHK;
      end
      ST_DONE: next_state_s = ST_IDLE;
      ST_ERR:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so registered outputs align with it.
  always_comb begin
    imem_en_s   = 1'b0;
    prog_ena_s  = 1'b0;
    load_done_s = 1'b0;
    load_err_s  = 1'b0;
    case (next_state_s)
      ST_CNT_LO, ST_CNT_HI, ST_DATA, ST_CHK: prog_ena_s = 1'b1;
      ST_WRITE: begin
        imem_en_s  = 1'b1;
        prog_ena_s = 1'b1;
      end
      ST_DONE: load_done_s = 1'b1;
      ST_ERR:  load_err_s  = 1'b1;
      default: prog_ena_s  = 1'b0;
    endcase
  end

  // Output registers; address and data hold between writes.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      imem_en_r   <= 1'b0;
      imem_we_r   <= 4'h0;
      imem_addr_r <= 32'h0000_0000;
      imem_din_r  <= 32'h0000_0000;
      prog_ena_r  <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      imem_en_r   <= imem_en_s;
      imem_we_r   <= imem_en_s ? 4'hF : 4'h0;
      prog_ena_r  <= prog_ena_s;
      load_done_r <= load_done_s;
      load_err_r  <= load_err_s;
      if (imem_en_s) begin
        imem_addr_r <= {14'd0, word_idx_r, 2'b00};
        imem_din_r  <= word_s;
      end else begin
        imem_addr_r <= imem_addr_r;
        imem_din_r  <= imem_din_r;
      end
    end
  end

  // Frame datapath: header count, word index, checksum and written-word counter.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_n_r         <= 16'd0;
      word_idx_r      <= 16'd0;
      words_written_r <= 16'd0;
      chk_r           <= CHK_INIT;
    end else begin
      if ((state_r == ST_CNT_LO) && bus.rx_valid)      cnt_n_r <= {8'h00, bus.rx_data};
      else if ((state_r == ST_CNT_HI) && bus.rx_valid) cnt_n_r <= n_full_s;
      else                                             cnt_n_r <= cnt_n_r;

      if (clear_s) begin
        word_idx_r      <= 16'd0;
        words_written_r <= 16'd0;
      end else if (state_r == ST_WRITE) begin
        word_idx_r      <= word_idx_r + 16'd1;
        words_written_r <= words_written_r + 16'd1;
      end else begin
        word_idx_r      <= word_idx_r;
        words_written_r <= words_written_r;
      end

      if (clear_s)       chk_r <= CHK_INIT;
      else if (accept_s) chk_r <= chk_update(chk_r, bus.rx_data);
      else               chk_r <= chk_r;
    end
  end

  // Inter-byte watchdog: restarts on every byte, idle outside the mid-frame wait states.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      to_cnt_r <= 32'd0;
    end else if (timing_s && !bus.rx_valid) begin
      to_cnt_r <= to_cnt_r + 32'd1;
    end else begin
      to_cnt_r <= 32'd0;
    end
  end

  assign bus.imem_en         = imem_en_r;
  assign bus.imem_we         = imem_we_r;
  assign bus.imem_addr       = imem_addr_r;
  assign bus.imem_din        = imem_din_r;
  assign bus.memcon_prog_ena = prog_ena_r;
  assign bus.load_done       = load_done_r;
  assign bus.load_err        = load_err_r;
  assign bus.words_written   = words_written_r;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: stimulus pushes expected writes/results,
// a negedge monitor pops and compares whenever the loader writes or pulses.
module tb_imem_uart_loader;
  import imem_loader_pkg::*;

  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_uart_loader_if bus();

  imem_uart_loader #(.DEPTH_WORDS(1024), .TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic ok; logic [15:0] ww; } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: compares every write and every done/err pulse against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_en) begin
        total++;
        if (exp_wr.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr %h data %h want no write", bus.imem_addr, bus.imem_din);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("write_we", {28'd0, bus.imem_we}, 32'h0000_000F);
          check("write_addr", bus.imem_addr, w.addr);
          check("write_data", bus.imem_din, w.data);
        end
      end
      if (bus.load_done || bus.load_err) begin
        total++;
        if (exp_res.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: got done %b err %b want none", bus.load_done, bus.load_err);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          check("load_done", {31'd0, bus.load_done}, {31'd0, r.ok});
          check("load_err", {31'd0, bus.load_err}, {31'd0, !r.ok});
          check("words_written", {16'd0, bus.words_written}, {16'd0, r.ww});
          check("prog_ena_at_end", {31'd0, bus.memcon_prog_ena}, 32'd0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Reference model: writes at word*4, checksum = XOR of every data byte.
  task automatic run_frame(input logic [31:0] words[$], input logic bad_chk, input int max_gap);
    logic [7:0]  c;
    logic [15:0] n;
    wr_t         w;
    res_t        r;
    c = 8'h00;
    n = 16'(words.size());
    for (int i = 0; i < words.size(); i++) begin
      w.addr = 32'(i * 4);
      w.data = words[i];
      exp_wr.push_back(w);
      for (int b = 0; b < 4; b++) c = c ^ words[i][8*b +: 8];
    end
    r.ok = !bad_chk;
    r.ww = n;
    exp_res.push_back(r);
    send(8'hA5);
    check("prog_after_sync", {31'd0, bus.memcon_prog_ena}, 32'd1);
    idle($urandom_range(max_gap, 0));
    send(n[7:0]);
    idle($urandom_range(max_gap, 0));
    send(n[15:8]);
    for (int i = 0; i < words.size(); i++) begin
      for (int b = 0; b < 4; b++) begin
        idle($urandom_range(max_gap, 0));
        send(words[i][8*b +: 8]);
      end
      check("write_latency", {31'd0, bus.imem_en}, 32'd1);
      check("prog_mid_frame", {31'd0, bus.memcon_prog_ena}, 32'd1);
    end
    idle($urandom_range(max_gap, 0));
    send(bad_chk ? (c ^ 8'h01) : c);
    check("prog_after_chk", {31'd0, bus.memcon_prog_ena}, 32'd0);
    idle(2);
  endtask

  initial begin
    logic [31:0] q[$];
    wr_t         w;
    res_t        r;
    logic [7:0]  j;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    idle(2);
    check("reset_prog", {31'd0, bus.memcon_prog_ena}, 32'd0);
    check("reset_en", {28'd0, bus.imem_we, bus.imem_en, bus.load_done, bus.load_err, 1'b0}, 32'd0);
    check("reset_addr", bus.imem_addr, 32'd0);
    check("reset_din", bus.imem_din, 32'd0);
    check("reset_ww", {16'd0, bus.words_written}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Two-word frame, good then corrupted checksum.
    q = '{32'h0000_0013, 32'h0010_0093};
    run_frame(q, 1'b0, 2);
    run_frame(q, 1'b1, 2);

    // Oversized header count 0x0401.
    r.ok = 1'b0; r.ww = 16'd0;
    exp_res.push_back(r);
    send(8'hA5); send(8'h01); send(8'h04);
    check("hdr_err_now", {31'd0, bus.load_err}, 32'd1);
    check("hdr_prog_drop", {31'd0, bus.memcon_prog_ena}, 32'd0);
    check("hdr_no_write", {31'd0, bus.imem_en}, 32'd0);
    idle(2);

    // Empty frames.
    q = {};
    run_frame(q, 1'b0, 1);
    run_frame(q, 1'b1, 1);

    // Timeout after 6 data bytes.
    w.addr = 32'd0; w.data = 32'hDDCC_BBAA;
    exp_wr.push_back(w);
    r.ok = 1'b0; r.ww = 16'd1;
    exp_res.push_back(r);
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'h11); send(8'h22);
    idle(TO - 1);
    check("timeout_not_early", {31'd0, bus.load_err}, 32'd0);
    idle(1);
    check("timeout_err", {31'd0, bus.load_err}, 32'd1);
    idle(2);

    // Back-to-back bytes, non-sync junk first.
    send(8'h55);
    q = '{32'h1234_5678, 32'hA5A5_00FF, 32'hCAFE_F00D};
    run_frame(q, 1'b0, 0);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(4, 0)); i++) q.push_back($urandom);
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        send(j);
      end
      run_frame(q, ($urandom_range(3, 0) == 0), 3);
    end

    // Reset mid-word-2: only word 1 written, no pulse afterwards.
    w.addr = 32'd0; w.data = 32'h4433_2211;
    exp_wr.push_back(w);
    send(8'hA5); send(8'h03); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    #2 rst_n = 1'b0;
    #1;
    check("rst_prog", {31'd0, bus.memcon_prog_ena}, 32'd0);
    check("rst_strobes", {28'd0, bus.imem_we, bus.imem_en, bus.load_done, bus.load_err, 1'b0}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);
    check("rst_din", bus.imem_din, 32'd0);
    check("rst_ww", {16'd0, bus.words_written}, 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(20);

    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
